// File: rtl/final_adder_pipe.sv
// rtl/final_adder_pipe.sv - two-stage hybrid carry-propagate adder resolving a redundant sum/carry pair
// Optional feature macro: FINAL_ADDER_OVF_EN (adds ovf_out, the sum-exceeds-width flag)
module final_adder_pipe #(
  parameter int PP_WIDTH  = 16,
  parameter int LOW_WIDTH = PP_WIDTH / 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PP_WIDTH-1:0] sum_in,
  input  logic [PP_WIDTH-1:0] carry_in,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef FINAL_ADDER_OVF_EN
  output logic                ovf_out,
`endif
  output logic [PP_WIDTH-1:0] result
);

  localparam int HI_WIDTH = PP_WIDTH - LOW_WIDTH;

  // Carry vector carries weight 2^(i+1); the shift drops its top bit from the sum.
  logic [PP_WIDTH-1:0]  carry_sh;
  logic [LOW_WIDTH:0]   lo_add;
  logic [HI_WIDTH-1:0]  hi_a;
  logic [HI_WIDTH-1:0]  hi_b;
  logic [HI_WIDTH-1:0]  hi_s0;
  logic [HI_WIDTH-1:0]  hi_s1;

  // Stage 1 state
  logic                 s1_valid_q, s1_valid_d;
  logic [LOW_WIDTH-1:0] lo_sum_q, lo_sum_d;
  logic                 lo_cout_q, lo_cout_d;
  logic [HI_WIDTH-1:0]  hi_sum0_q, hi_sum0_d;
  logic [HI_WIDTH-1:0]  hi_sum1_q, hi_sum1_d;

  // Stage 2 state
  logic                 s2_valid_q, s2_valid_d;
  logic [PP_WIDTH-1:0]  result_q, result_d;

  logic                 s1_adv;
  logic                 s2_adv;

`ifdef FINAL_ADDER_OVF_EN
  logic                 hi_c0;
  logic                 hi_c1;
  logic                 hi_ovf0_q, hi_ovf0_d;
  logic                 hi_ovf1_q, hi_ovf1_d;
  logic                 ovf_q, ovf_d;
`endif

  // Segment adders: ripple low half, both carry-in speculations for the high half.
  always_comb begin
    carry_sh = carry_in << 1;
    lo_add   = {1'b0, sum_in[LOW_WIDTH-1:0]} + {1'b0, carry_sh[LOW_WIDTH-1:0]};
    hi_a     = sum_in[PP_WIDTH-1:LOW_WIDTH];
    hi_b     = carry_sh[PP_WIDTH-1:LOW_WIDTH];
`ifdef FINAL_ADDER_OVF_EN
    {hi_c0, hi_s0} = {1'b0, hi_a} + {1'b0, hi_b};
    {hi_c1, hi_s1} = {1'b0, hi_a} + {1'b0, hi_b} + (HI_WIDTH + 1)'(1);
`else
    hi_s0 = hi_a + hi_b;
    hi_s1 = hi_a + hi_b + HI_WIDTH'(1);
`endif
  end

  // Handshake: a stage advances when it is empty or its consumer takes the beat.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  // Next-state for both stages; data moves only when its stage advances with a valid beat.
  always_comb begin
    s1_valid_d = s1_valid_q;
    lo_sum_d   = lo_sum_q;
    lo_cout_d  = lo_cout_q;
    hi_sum0_d  = hi_sum0_q;
    hi_sum1_d  = hi_sum1_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
`ifdef FINAL_ADDER_OVF_EN
    hi_ovf0_d  = hi_ovf0_q;
    hi_ovf1_d  = hi_ovf1_q;
    ovf_d      = ovf_q;
`endif
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        lo_sum_d  = lo_add[LOW_WIDTH-1:0];
        lo_cout_d = lo_add[LOW_WIDTH];
        hi_sum0_d = hi_s0;
        hi_sum1_d = hi_s1;
`ifdef FINAL_ADDER_OVF_EN
        // The discarded carry MSB alone already means the sum overflows.
        hi_ovf0_d = hi_c0 | carry_in[PP_WIDTH-1];
        hi_ovf1_d = hi_c1 | carry_in[PP_WIDTH-1];
`endif
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = {(lo_cout_q ? hi_sum1_q : hi_sum0_q), lo_sum_q};
`ifdef FINAL_ADDER_OVF_EN
        ovf_d    = lo_cout_q ? hi_ovf1_q : hi_ovf0_q;
`endif
      end
    end
  end

  // Pipeline registers with synchronous active-low reset; in-flight beats are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      lo_sum_q   <= '0;
      lo_cout_q  <= 1'b0;
      hi_sum0_q  <= '0;
      hi_sum1_q  <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
`ifdef FINAL_ADDER_OVF_EN
      hi_ovf0_q  <= 1'b0;
      hi_ovf1_q  <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      lo_sum_q   <= lo_sum_d;
      lo_cout_q  <= lo_cout_d;
      hi_sum0_q  <= hi_sum0_d;
      hi_sum1_q  <= hi_sum1_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
`ifdef FINAL_ADDER_OVF_EN
      hi_ovf0_q  <= hi_ovf0_d;
      hi_ovf1_q  <= hi_ovf1_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
`ifdef FINAL_ADDER_OVF_EN
  assign ovf_out   = ovf_q;
`endif

endmodule

// File: tb/tb_final_adder_pipe.sv
// tb/tb_final_adder_pipe.sv - directed and streaming checks of final_adder_pipe against a queue model
module tb_final_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum_in;
  logic [15:0] carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
`ifdef FINAL_ADDER_OVF_EN
  logic        ovf_out;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;

  logic [16:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [15:0] held;

  final_adder_pipe #(.PP_WIDTH(16), .LOW_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum_in   (sum_in),
    .carry_in (carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef FINAL_ADDER_OVF_EN
    .ovf_out  (ovf_out),
`endif
    .result   (result)
  );

  always #5 clk = ~clk;

  // Reference: plain integer sum of sum + 2*carry; overflow when it no longer fits 16 bits.
  function automatic logic [16:0] model(input logic [15:0] s, input logic [15:0] c);
    int t;
    t = int'(s) + 2 * int'(c);
    model = {(t > 65535), 16'(t)};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: record accepted beats, check each delivered result in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (out_valid && exp_q.size() == 0) begin
        cmp("spurious_out_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        if (stall_prev) cmp("stall_stable", 32'(result), 32'(held));
        if (out_ready) begin
          logic [16:0] e;
          e = exp_q.pop_front();
          cmp("model_result", 32'(result), 32'(e[15:0]));
`ifdef FINAL_ADDER_OVF_EN
          cmp("model_ovf", 32'(ovf_out), 32'(e[16]));
`endif
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(sum_in, carry_in));
        n_in++;
      end
      stall_prev = out_valid && !out_ready;
      held       = result;
    end
  end

  // One beat into an empty pipe with out_ready high; output appears after the second register edge.
  task automatic send_one(input logic [15:0] s, input logic [15:0] c,
                          input logic [15:0] exp_r, input logic exp_o, input string name);
    @(posedge clk); #1;
    in_valid = 1'b1; sum_in = s; carry_in = c;
    @(negedge clk);
    cmp({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; sum_in = 'x; carry_in = 'x;
    @(negedge clk);
    cmp({name, "_early_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    cmp({name, "_out_valid"}, 32'(out_valid), 32'd1);
    cmp({name, "_result"}, 32'(result), 32'(exp_r));
`ifdef FINAL_ADDER_OVF_EN
    cmp({name, "_ovf"}, 32'(ovf_out), 32'(exp_o));
`else
    if (exp_o === 1'bx) $display("note: unknown ovf expectation");
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sum_in = '0; carry_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    cmp("reset_out_valid", 32'(out_valid), 32'd0);
    cmp("reset_result", 32'(result), 32'd0);
    cmp("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed arithmetic, including segment carry crossing and wrap.
    send_one(16'h1234, 16'h0001, 16'h1236, 1'b0, "single");
    send_one(16'h00FF, 16'h0001, 16'h0101, 1'b0, "lo_carry");
    send_one(16'hFFFF, 16'h0001, 16'h0001, 1'b1, "wrap_sum");
    send_one(16'h0000, 16'h8000, 16'h0000, 1'b1, "wrap_cmsb");

    // Backpressure: A and B fill both stages, C is refused until out_ready rises.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; sum_in = 16'h0001; carry_in = 16'h0001;
    @(posedge clk); #1;
    sum_in = 16'h0010; carry_in = 16'h0000;
    @(posedge clk); #1;
    sum_in = 16'h0100; carry_in = 16'h0080;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("bp_in_ready", 32'(in_ready), 32'd0);
      cmp("bp_hold_A", 32'(result), 32'h0003);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    cmp("bp_out_A", 32'(result), 32'h0003);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    cmp("bp_out_B", 32'(result), 32'h0010);
    @(posedge clk); #1;
    @(negedge clk);
    cmp("bp_out_C_valid", 32'(out_valid), 32'd1);
    cmp("bp_out_C", 32'(result), 32'h0200);
    @(posedge clk); #1;

    // Reset mid-operation with both stages full.
    out_ready = 1'b0; in_valid = 1'b1; sum_in = 16'h1111; carry_in = 16'h1111;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    cmp("rst_full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0; sum_in = 16'h2222; carry_in = 16'h0001;
    @(posedge clk); #1;
    @(negedge clk);
    cmp("rst_mid_out_valid", 32'(out_valid), 32'd0);
    cmp("rst_mid_result", 32'(result), 32'd0);
    cmp("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("rst_no_old_beats", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    send_one(16'h4000, 16'h2000, 16'h8000, 1'b0, "post_rst");

    // Random streaming with random back-pressure.
    begin
      int sent = 0;
      int cyc  = 0;
      logic acc;
      int in0;
      int out0;
      @(posedge clk); #1;
      in0 = n_in; out0 = n_out;
      while (sent < 1000 && cyc < 20000) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        cyc++;
        if (acc) sent++;
        if (!in_valid || acc) begin
          if (sent < 1000 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1; sum_in = 16'($urandom); carry_in = 16'($urandom);
          end else begin
            in_valid = 1'b0;
          end
        end
        out_ready = ($urandom_range(0, 2) != 0);
      end
      in_valid = 1'b0;
      cmp("stream_sent_all", 32'(sent), 32'd1000);
      out_ready = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      @(negedge clk);
      cmp("stream_drained", 32'(exp_q.size()), 32'd0);
      cmp("stream_count", 32'(n_out - out0), 32'(n_in - in0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
